// File: rtl/ni_traffic_source.sv
// rtl/ni_traffic_source.sv - synthetic flit generator for a router local injection port
module ni_traffic_source #(
  parameter int          ADDR_SZ   = 4,
  parameter int          PL_SZ     = 16,
  parameter int          HDR_SZ    = 2,
  parameter int          HDR_VAL   = 1,
  parameter int          NODES     = 16,
  parameter int          GAP       = 4,
  parameter int          MAX_FLITS = 0,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [ADDR_SZ-1:0]                id,
  input  logic                              send_en,
  output logic [HDR_SZ+PL_SZ+ADDR_SZ-1:0]   item_out,
  output logic                              req,
  input  logic                              channel_busy,
  output logic [19:0]                       sent_count,
  output logic                              done
);

  localparam int                SEQ_SZ   = PL_SZ - ADDR_SZ;
  localparam int                GAP_W    = (GAP > 1) ? $clog2(GAP + 1) : 1;
  localparam logic [GAP_W-1:0]  GAP_INIT = GAP_W'(GAP);
  localparam logic [15:0]       SEED_EFF = (SEED == 16'h0) ? 16'hACE1 : SEED;
  localparam logic [HDR_SZ-1:0] HDR      = HDR_SZ'(HDR_VAL);
  localparam logic [ADDR_SZ:0]  NODES_L  = (ADDR_SZ + 1)'(NODES);
  localparam logic [19:0]       BUDGET   = 20'(MAX_FLITS);

  typedef enum logic [2:0] {S_IDLE, S_GAP, S_LOAD, S_SEND, S_DONE} state_t;

  state_t             state;
  logic [SEQ_SZ-1:0]  seq;
  logic [15:0]        lfsr;
  logic [GAP_W-1:0]   gap_cnt;

  logic [15:0]        lfsr_nx;
  logic [ADDR_SZ-1:0] cand;
  logic               cand_bad;
  logic [19:0]        cnt_nx;
  logic               budget_hit;

  assign lfsr_nx    = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign cand       = lfsr[ADDR_SZ-1:0];
  assign cand_bad   = ({1'b0, cand} >= NODES_L) || (cand == id);
  assign cnt_nx     = (sent_count == 20'hFFFFF) ? sent_count : sent_count + 20'd1;
  assign budget_hit = (MAX_FLITS != 0) && (cnt_nx == BUDGET);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      seq        <= '0;
      lfsr       <= SEED_EFF;
      gap_cnt    <= '0;
      req        <= 1'b0;
      item_out   <= '0;
      sent_count <= '0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (send_en) begin
            if (GAP > 0) begin
              gap_cnt <= GAP_INIT;
              state   <= S_GAP;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        S_GAP: begin
          if (!send_en) begin
            state <= S_IDLE;
          end else if (gap_cnt <= GAP_W'(1)) begin
            gap_cnt <= '0;
            state   <= S_LOAD;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        // Rejected candidates reroll the LFSR one per cycle until a legal destination appears
        S_LOAD: begin
          if (!send_en) begin
            state <= S_IDLE;
          end else if (cand_bad) begin
            lfsr <= lfsr_nx;
          end else begin
            item_out <= {HDR, id, seq, cand};
            req      <= 1'b1;
            state    <= S_SEND;
          end
        end
        S_SEND: begin
          if (!channel_busy) begin
            req        <= 1'b0;
            seq        <= seq + SEQ_SZ'(1);
            sent_count <= cnt_nx;
            lfsr       <= lfsr_nx;
            if (budget_hit) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else if (send_en) begin
              if (GAP > 0) begin
                gap_cnt <= GAP_INIT;
                state   <= S_GAP;
              end else begin
                state <= S_LOAD;
              end
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_DONE: begin
          req  <= 1'b0;
          done <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ni_traffic_source.sv
// tb/tb_ni_traffic_source.sv - directed bench for ni_traffic_source
module tb_ni_traffic_source;

  logic        clk;
  logic        reset;
  logic [3:0]  id_v      [4];
  logic        send_en_v [4];
  logic        busy_v    [4];
  logic [21:0] item_v    [4];
  logic        req_v     [4];
  logic [19:0] cnt_v     [4];
  logic        done_v    [4];

  int vectors;
  int miscompares;

  ni_traffic_source #(.GAP(0)) u0 (
    .clk(clk), .reset(reset), .id(id_v[0]), .send_en(send_en_v[0]), .item_out(item_v[0]),
    .req(req_v[0]), .channel_busy(busy_v[0]), .sent_count(cnt_v[0]), .done(done_v[0]));
  ni_traffic_source #(.GAP(4)) u1 (
    .clk(clk), .reset(reset), .id(id_v[1]), .send_en(send_en_v[1]), .item_out(item_v[1]),
    .req(req_v[1]), .channel_busy(busy_v[1]), .sent_count(cnt_v[1]), .done(done_v[1]));
  ni_traffic_source #(.GAP(0), .NODES(6)) u2 (
    .clk(clk), .reset(reset), .id(id_v[2]), .send_en(send_en_v[2]), .item_out(item_v[2]),
    .req(req_v[2]), .channel_busy(busy_v[2]), .sent_count(cnt_v[2]), .done(done_v[2]));
  ni_traffic_source #(.GAP(0), .MAX_FLITS(3)) u3 (
    .clk(clk), .reset(reset), .id(id_v[3]), .send_en(send_en_v[3]), .item_out(item_v[3]),
    .req(req_v[3]), .channel_busy(busy_v[3]), .sent_count(cnt_v[3]), .done(done_v[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_nx(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Leaves the bench on a falling edge with reset released and all sources idle
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send_en_v[k] = 1'b0;
      busy_v[k]    = 1'b0;
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send_en_v[k] = 1'b1;
      busy_v[k]    = 1'b0;
    end
    repeat (2) @(negedge clk);
    vectors++; if (req_v[0] !== 1'b0) begin miscompares++; $display("FAIL reset_req got %b want 0", req_v[0]); end
    vectors++; if (item_v[0] !== 22'd0) begin miscompares++; $display("FAIL reset_item got %h want 0", item_v[0]); end
    vectors++; if (cnt_v[0] !== 20'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", cnt_v[0]); end
    vectors++; if (done_v[3] !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done_v[3]); end
    for (int k = 0; k < 4; k++) send_en_v[k] = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [15:0] l;
    logic [11:0] seq;
    logic [21:0] exp_item;
    int waited, exp_wait;
    do_reset();
    l = 16'hACE1;
    seq = '0;
    send_en_v[0] = 1'b1;
    for (int f = 0; f < 10; f++) begin
      exp_wait = 2;
      while (l[3:0] == 4'd3) begin l = lfsr_nx(l); exp_wait++; end
      exp_item = {2'd1, 4'd3, seq, l[3:0]};
      waited = 0;
      do begin @(negedge clk); waited++; end while (req_v[0] !== 1'b1 && waited < 50);
      vectors++; if (waited !== exp_wait) begin miscompares++; $display("FAIL basic_latency flit %0d got %0d want %0d", f, waited, exp_wait); end
      vectors++; if (item_v[0] !== exp_item) begin miscompares++; $display("FAIL basic_item flit %0d got %h want %h", f, item_v[0], exp_item); end
      l = lfsr_nx(l);
      seq = seq + 12'd1;
    end
    send_en_v[0] = 1'b0;
    @(negedge clk);
    vectors++; if (cnt_v[0] !== 20'd10) begin miscompares++; $display("FAIL basic_count got %0d want 10", cnt_v[0]); end
  endtask

  task automatic test_busy_hold();
    logic [21:0] exp_item;
    int waited;
    do_reset();
    exp_item = {2'd1, 4'd3, 12'd0, 4'd1};
    busy_v[0] = 1'b1;
    send_en_v[0] = 1'b1;
    waited = 0;
    do begin @(negedge clk); waited++; end while (req_v[0] !== 1'b1 && waited < 50);
    vectors++; if (waited !== 2) begin miscompares++; $display("FAIL busy_first_req got %0d want 2", waited); end
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      vectors++; if (req_v[0] !== 1'b1 || item_v[0] !== exp_item) begin
        miscompares++; $display("FAIL busy_hold cycle %0d got req=%b item=%h want req=1 item=%h", c, req_v[0], item_v[0], exp_item);
      end
    end
    vectors++; if (cnt_v[0] !== 20'd0) begin miscompares++; $display("FAIL busy_count_held got %0d want 0", cnt_v[0]); end
    busy_v[0] = 1'b0;
    @(negedge clk);
    send_en_v[0] = 1'b0;
    vectors++; if (req_v[0] !== 1'b0 || cnt_v[0] !== 20'd1) begin
      miscompares++; $display("FAIL busy_accept got req=%b count=%0d want req=0 count=1", req_v[0], cnt_v[0]);
    end
    repeat (3) @(negedge clk);
    vectors++; if (cnt_v[0] !== 20'd1) begin miscompares++; $display("FAIL busy_single_count got %0d want 1", cnt_v[0]); end
  endtask

  task automatic test_gap();
    logic [15:0] l;
    logic [11:0] seq;
    logic [21:0] exp_item;
    int waited, exp_wait;
    do_reset();
    l = 16'hACE1;
    seq = '0;
    send_en_v[1] = 1'b1;
    for (int f = 0; f < 20; f++) begin
      exp_wait = 6;
      while (l[3:0] == 4'd3) begin l = lfsr_nx(l); exp_wait++; end
      exp_item = {2'd1, 4'd3, seq, l[3:0]};
      waited = 0;
      do begin @(negedge clk); waited++; end while (req_v[1] !== 1'b1 && waited < 50);
      vectors++; if (waited !== exp_wait) begin miscompares++; $display("FAIL gap_spacing flit %0d got %0d want %0d", f, waited, exp_wait); end
      vectors++; if (item_v[1] !== exp_item) begin miscompares++; $display("FAIL gap_item flit %0d got %h want %h", f, item_v[1], exp_item); end
      l = lfsr_nx(l);
      seq = seq + 12'd1;
    end
    send_en_v[1] = 1'b0;
    @(negedge clk);
    vectors++; if (cnt_v[1] !== 20'd20) begin miscompares++; $display("FAIL gap_count got %0d want 20", cnt_v[1]); end
  endtask

  task automatic test_dest_range();
    logic seen [6];
    int bad, waited, timeouts;
    logic [3:0] dest;
    do_reset();
    for (int d = 0; d < 6; d++) seen[d] = 1'b0;
    bad = 0;
    timeouts = 0;
    send_en_v[2] = 1'b1;
    for (int f = 0; f < 1000; f++) begin
      waited = 0;
      do begin @(negedge clk); waited++; end while (req_v[2] !== 1'b1 && waited < 200);
      if (req_v[2] !== 1'b1) begin timeouts++; break; end
      dest = item_v[2][3:0];
      if (dest >= 4'd6 || dest == 4'd5) bad++;
      else seen[dest] = 1'b1;
    end
    send_en_v[2] = 1'b0;
    @(negedge clk);
    vectors++; if (timeouts !== 0) begin miscompares++; $display("FAIL range_timeout got %0d want 0", timeouts); end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL range_illegal_dest got %0d want 0", bad); end
    for (int d = 0; d < 5; d++) begin
      vectors++; if (seen[d] !== 1'b1) begin miscompares++; $display("FAIL range_cover dest %0d got %b want 1", d, seen[d]); end
    end
    vectors++; if (cnt_v[2] !== 20'd1000) begin miscompares++; $display("FAIL range_count got %0d want 1000", cnt_v[2]); end
  endtask

  task automatic test_budget();
    int transfers, third, done_at;
    do_reset();
    transfers = 0;
    third = -1;
    done_at = -1;
    send_en_v[3] = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done_v[3] === 1'b1 && done_at < 0) done_at = c;
      if (req_v[3] === 1'b1) begin
        transfers++;
        if (transfers == 3) third = c;
      end
    end
    vectors++; if (transfers !== 3) begin miscompares++; $display("FAIL budget_transfers got %0d want 3", transfers); end
    vectors++; if (third < 0 || done_at !== third + 1) begin miscompares++; $display("FAIL budget_done_cycle got %0d want %0d", done_at, third + 1); end
    vectors++; if (cnt_v[3] !== 20'd3) begin miscompares++; $display("FAIL budget_count got %0d want 3", cnt_v[3]); end
    vectors++; if (done_v[3] !== 1'b1 || req_v[3] !== 1'b0) begin
      miscompares++; $display("FAIL budget_final got done=%b req=%b want done=1 req=0", done_v[3], req_v[3]);
    end
    send_en_v[3] = 1'b0;
  endtask

  task automatic test_drop_in_gap();
    int req_seen, waited;
    do_reset();
    send_en_v[1] = 1'b1;
    repeat (2) @(negedge clk);
    send_en_v[1] = 1'b0;
    req_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_v[1] === 1'b1) req_seen++;
    end
    vectors++; if (req_seen !== 0 || cnt_v[1] !== 20'd0) begin
      miscompares++; $display("FAIL gap_drop got req_cycles=%0d count=%0d want 0 0", req_seen, cnt_v[1]);
    end
    // seed low nibble 1 is a legal destination, so a fresh start from IDLE takes GAP+2 cycles
    send_en_v[1] = 1'b1;
    waited = 0;
    do begin @(negedge clk); waited++; end while (req_v[1] !== 1'b1 && waited < 50);
    vectors++; if (waited !== 6) begin miscompares++; $display("FAIL gap_restart got %0d want 6", waited); end
    send_en_v[1] = 1'b0;
  endtask

  task automatic test_drop_in_send();
    int waited, req_seen;
    do_reset();
    busy_v[0] = 1'b1;
    send_en_v[0] = 1'b1;
    waited = 0;
    do begin @(negedge clk); waited++; end while (req_v[0] !== 1'b1 && waited < 50);
    send_en_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (req_v[0] !== 1'b1) begin miscompares++; $display("FAIL send_drop_hold got %b want 1", req_v[0]); end
    busy_v[0] = 1'b0;
    @(negedge clk);
    vectors++; if (req_v[0] !== 1'b0 || cnt_v[0] !== 20'd1) begin
      miscompares++; $display("FAIL send_drop_deliver got req=%b count=%0d want req=0 count=1", req_v[0], cnt_v[0]);
    end
    req_seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (req_v[0] === 1'b1) req_seen++;
    end
    vectors++; if (req_seen !== 0 || cnt_v[0] !== 20'd1) begin
      miscompares++; $display("FAIL send_drop_idle got req_cycles=%0d count=%0d want 0 1", req_seen, cnt_v[0]);
    end
  endtask

  task automatic test_reset_mid_send();
    int waited;
    do_reset();
    send_en_v[0] = 1'b1;
    waited = 0;
    do begin @(negedge clk); waited++; end while (cnt_v[0] < 20'd2 && waited < 50);
    busy_v[0] = 1'b1;
    waited = 0;
    do begin @(negedge clk); waited++; end while (req_v[0] !== 1'b1 && waited < 50);
    vectors++; if (req_v[0] !== 1'b1 || cnt_v[0] !== 20'd2) begin
      miscompares++; $display("FAIL midsend_setup got req=%b count=%0d want req=1 count=2", req_v[0], cnt_v[0]);
    end
    reset = 1'b1;
    @(negedge clk);
    vectors++; if (req_v[0] !== 1'b0 || cnt_v[0] !== 20'd0 || item_v[0] !== 22'd0) begin
      miscompares++; $display("FAIL midsend_reset got req=%b count=%0d item=%h want 0 0 0", req_v[0], cnt_v[0], item_v[0]);
    end
    reset = 1'b0;
    send_en_v[0] = 1'b0;
    busy_v[0] = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    id_v[0] = 4'd3;
    id_v[1] = 4'd3;
    id_v[2] = 4'd5;
    id_v[3] = 4'd3;
    for (int k = 0; k < 4; k++) begin
      send_en_v[k] = 1'b0;
      busy_v[k]    = 1'b0;
    end
    test_reset();
    test_basic();
    test_busy_hold();
    test_gap();
    test_dest_range();
    test_budget();
    test_drop_in_gap();
    test_drop_in_send();
    test_reset_mid_send();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
